svc_rv_soc_bench_runner: RTL
============================

Name: svc_rv_soc_bench_runner

Overview:
Run controller placed beside an svc_rv_soc_* instance in demo tops, replacing a free-running core with measured, repeatable runs. Per start it holds the core in reset, releases it, counts cycles until ebreak, trap or timeout, and repeats for RUNS iterations. Each run emits one result on a valid/ready stream, and min/max/total cycles are kept for CPI reporting.

Parameters:
CNT_W, 32, width of per-run cycle counter and the min/max registers
RUNS, 4, number of runs per start (>=1)
TIMEOUT, 1000000, cycle count at which a run is aborted (1 <= TIMEOUT < 2**CNT_W)
RST_CYCLES, 4, cycles core_rst_n is held low before each run (>=1)
RUN_W, $clog2(RUNS)+1, width of run index; total width TOT_W = CNT_W+RUN_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle start request
core_rst_n  out  1  active-low reset driven to the SoC
ebreak  in  1  SoC ebreak flag
trap  in  1  SoC trap flag
busy  out  1  high from accepted start until DONE is reached
done  out  1  one-cycle pulse when the last result has been accepted
res_valid  out  1  result stream valid
res_ready  in  1  result stream ready
res_cycles  out  CNT_W  cycles for this run
res_idx  out  RUN_W  run index, 0..RUNS-1
res_status  out  2  0=ebreak, 1=trap, 2=timeout
min_cycles  out  CNT_W  minimum over ebreak-status runs of the last batch
max_cycles  out  CNT_W  maximum over ebreak-status runs
total_cycles  out  TOT_W  sum of res_cycles over all runs of the last batch
ok_runs  out  RUN_W  count of ebreak-status runs

Behaviour:
- Clock is clk. Reset is rst: one clock domain, asynchronous assert, active-high.
- Reset values: core_rst_n=0, busy=0, done=0, res_valid=0, res_cycles=0, res_idx=0, res_status=0, min_cycles=all-ones, max_cycles=0, total_cycles=0, ok_runs=0, state=IDLE.
- FSM states: IDLE, HOLD, RUN, REPORT, DONE.
- IDLE:
  - core_rst_n=0.
  - start=1 clears the statistics (min to all-ones, others to 0) and sets idx=0, busy=1, then goes to HOLD.
- HOLD:
  - core_rst_n=0 for exactly RST_CYCLES cycles.
  - Cycle counter cleared; then go to RUN.
- RUN:
  - core_rst_n=1. The counter increments every RUN cycle; the first RUN cycle counts as 1.
  - On the cycle ebreak or trap is sampled high, that cycle's count is latched into res_cycles (inclusive) and the FSM goes to REPORT.
  - trap and ebreak high in the same cycle gives status 1 (trap wins).
  - If the count reaches TIMEOUT with neither flag seen, status=2, res_cycles=TIMEOUT, go to REPORT.
  - ebreak/trap outside RUN are ignored.
- REPORT:
  - core_rst_n=0 (the core is held again on the entry cycle).
  - res_valid=1 with res_cycles/res_idx/res_status stable until the handshake res_valid&&res_ready.
  - Statistics update on the handshake cycle:
    - total_cycles += res_cycles for every status.
    - min/max/ok_runs update only for status 0.
  - After the handshake: if idx==RUNS-1, go to DONE; else idx++ and go to HOLD.
  - res_valid drops the cycle after the handshake. res_ready while res_valid=0 has no effect.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
  - Statistics hold until the next accepted start.
- start while busy is ignored. start in the DONE cycle is ignored.
- rst mid-run returns immediately to reset values, with core_rst_n low asynchronously. No partial result is emitted.
- Minimum latency from start to the first res_valid is 1+RST_CYCLES+N cycles, where N is the ebreak cycle count.
- No arithmetic overflow is possible: TOT_W covers RUNS*(2**CNT_W-1).

Test Plan:
1. RST_CYCLES=4, RUNS=1; model asserts ebreak on the 18th cycle after core_rst_n rises -> core_rst_n low for 4 cycles; one result {cycles=18, idx=0, status=0}; min=max=total=18, ok_runs=1; done pulses once.
2. RUNS=4; ebreak after 10, 12, 11, 15 cycles with res_ready always 1 -> idx 0..3 in order; min=10, max=15, total=48, ok_runs=4; core_rst_n low 4 cycles between runs.
3. TIMEOUT=50, core never flags -> status=2, cycles=50; total includes 50; min stays all-ones and ok_runs=0 for a single-run batch.
4. trap and ebreak together at cycle 7 -> status=1, cycles=7; min/max unchanged; total+=7.
5. res_ready held 0 for 20 cycles -> res_valid and payload stable; next HOLD starts only after the handshake; start pulses while busy are ignored.
6. rst asserted mid-RUN at cycle 5 -> core_rst_n=0 and res_valid=0 immediately; busy=0; next start yields a clean batch with idx=0 and cleared statistics.

Source files
------------

// File: rtl/svc_rv_soc_bench_runner.sv
// Run controller for an svc_rv_soc_* instance: holds the core in reset, times each run
// until ebreak/trap/timeout, streams one result per run and keeps min/max/total statistics.
module svc_rv_soc_bench_runner #(
  parameter int CNT_W      = 32,
  parameter int RUNS       = 4,
  parameter int TIMEOUT    = 1000000,
  parameter int RST_CYCLES = 4,
  parameter int RUN_W      = $clog2(RUNS) + 1,
  parameter int TOT_W      = CNT_W + RUN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             core_rst_n,
  input  logic             ebreak,
  input  logic             trap,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_cycles,
  output logic [RUN_W-1:0] res_idx,
  output logic [1:0]       res_status,
  output logic [CNT_W-1:0] min_cycles,
  output logic [CNT_W-1:0] max_cycles,
  output logic [TOT_W-1:0] total_cycles,
  output logic [RUN_W-1:0] ok_runs
);

  typedef enum logic [2:0] {IDLE, HOLD, RUN, REPORT, DONE} state_t;

  localparam int HOLD_W = $clog2(RST_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [RUN_W-1:0]  IDX_LAST  = RUN_W'(RUNS - 1);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cnt;

  // Run sequencer; res_idx doubles as the run index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      cnt          <= '0;
      core_rst_n   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      res_valid    <= 1'b0;
      res_cycles   <= '0;
      res_idx      <= '0;
      res_status   <= 2'd0;
      min_cycles   <= '1;
      max_cycles   <= '0;
      total_cycles <= '0;
      ok_runs      <= '0;
    end else begin
      case (state)
        IDLE: begin
          core_rst_n <= 1'b0;
          if (start) begin
            min_cycles   <= '1;
            max_cycles   <= '0;
            total_cycles <= '0;
            ok_runs      <= '0;
            res_idx      <= '0;
            busy         <= 1'b1;
            hold_cnt     <= '0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            cnt        <= CNT_W'(1);
            core_rst_n <= 1'b1;
            state      <= RUN;
          end else begin
            cnt      <= '0;
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          // A flag on the timeout cycle still counts as a real completion.
          if (trap || ebreak) begin
            res_cycles <= cnt;
            res_status <= trap ? 2'd1 : 2'd0;
            res_valid  <= 1'b1;
            core_rst_n <= 1'b0;
            state      <= REPORT;
          end else if (cnt == TIMEOUT_C) begin
            res_cycles <= TIMEOUT_C;
            res_status <= 2'd2;
            res_valid  <= 1'b1;
            core_rst_n <= 1'b0;
            state      <= REPORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid    <= 1'b0;
            total_cycles <= total_cycles + TOT_W'(res_cycles);
            if (res_status == 2'd0) begin
              ok_runs <= ok_runs + RUN_W'(1);
              if (res_cycles < min_cycles) begin
                min_cycles <= res_cycles;
              end
              if (res_cycles > max_cycles) begin
                max_cycles <= res_cycles;
              end
            end
            if (res_idx == IDX_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              res_idx  <= res_idx + RUN_W'(1);
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          core_rst_n <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          res_valid  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
